// File: rtl/data_mem_ctrl_if.sv
// ============================================================================
//  Module      : data_mem_ctrl_if
//  Description : Core-side request/response bundle for data_mem_ctrl.
//                master = core (requester), slave = controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Access sequencer for a 16-bit byte-addressable data RAM.
//                One load/store at a time; generates active-low read/write
//                strobes and byte-mode bit, drives/releases the tri-state
//                data bus and returns a single-cycle response.
//                Optional macro DATA_MEM_ALIGN_CHECK_EN: odd-address word
//                requests are suppressed and answered with rsp_err=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter logic [15:0] RESET_RDATA = 16'h0000
) (
    input  wire               clk,
    input  wire               rst_n,
    data_mem_ctrl_if.slave    core,
    output logic [15:0]       mem_addr,
    inout  wire  [15:0]       mem_data,
    output logic              mem_read_en_n,
    output logic              mem_write_en_n,
    output logic              mem_ebit
);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_SETUP   = 3'd1,
        S_RD_CAPTURE = 3'd2,
        S_WR_SETUP   = 3'd3,
        S_WR_STROBE  = 3'd4,
        S_WR_HOLD    = 3'd5,
        S_RSP        = 3'd6
    } state_t;

    state_t      state_d, state_q;
    logic        ready_d, ready_q;
    logic        rsp_valid_d, rsp_valid_q;
    logic [15:0] rdata_d, rdata_q;
    logic        err_d, err_q;
    logic        rd_n_d, rd_n_q;
    logic        wr_n_d, wr_n_q;
    logic        drive_d, drive_q;
    logic [15:0] addr_d, addr_q;
    logic        ebit_d, ebit_q;
    logic        signed_d, signed_q;
    logic [15:0] wdata_d, wdata_q;
    logic [15:0] load_data;

    // Load result formatting; the upper bus byte is ignored for byte loads
    always_comb begin
        load_data = mem_data;
        if (ebit_q) begin
            load_data = {{8{signed_q & mem_data[7]}}, mem_data[7:0]};
        end
    end

    // Next-state and next-output logic; every output is registered so the
    // strobes and bus enable are glitch-free and aligned with the state
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        drive_d     = 1'b0;
        addr_d      = addr_q;
        ebit_d      = ebit_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (core.req_valid && ready_q) begin
                    ready_d  = 1'b0;
                    addr_d   = core.req_addr;
                    ebit_d   = core.req_byte;
                    signed_d = core.req_signed;
                    wdata_d  = core.req_byte ? {8'h00, core.req_wdata[7:0]}
                                             : core.req_wdata;
                    if (ALIGN_CHECK && !core.req_byte && core.req_addr[0]) begin
                        // Misaligned word: no strobe, no bus, error response
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else if (core.req_write) begin
                        state_d = S_WR_SETUP;
                        drive_d = 1'b1;
                    end else begin
                        state_d = S_RD_SETUP;
                        rd_n_d  = 1'b0;
                    end
                end
            end
            S_RD_SETUP: begin
                state_d = S_RD_CAPTURE;
                rd_n_d  = 1'b0;
            end
            S_RD_CAPTURE: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                err_d       = 1'b0;
                rdata_d     = load_data;
            end
            S_WR_SETUP: begin
                state_d = S_WR_STROBE;
                drive_d = 1'b1;
                wr_n_d  = 1'b0;
            end
            S_WR_STROBE: begin
                // Strobe rises here; data and address held one more cycle
                state_d = S_WR_HOLD;
                drive_d = 1'b1;
            end
            S_WR_HOLD: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                err_d       = 1'b0;
                rdata_d     = RESET_RDATA;
            end
            S_RSP: begin
                // Following IDLE cycle doubles as the bus turnaround
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= RESET_RDATA;
            err_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            addr_q      <= 16'h0000;
            ebit_q      <= 1'b0;
            signed_q    <= 1'b0;
            wdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            drive_q     <= drive_d;
            addr_q      <= addr_d;
            ebit_q      <= ebit_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
        end
    end

    assign core.req_ready = ready_q;
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_rdata = rdata_q;
    assign core.rsp_err   = err_q;
    assign mem_addr       = addr_q;
    assign mem_ebit       = ebit_q;
    assign mem_read_en_n  = rd_n_q;
    assign mem_write_en_n = wr_n_q;
    assign mem_data       = drive_q ? wdata_q : 16'bz;

endmodule

`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Access sequencer directly upstream of the 16-bit byte-addressable data RAM.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Generates the RAM's active-low read and write strobes and the byte-mode bit, and drives or releases the shared tri-state data bus.
- Captures load data, then returns a single-cycle response with zero- or sign-extension for byte loads.

Parameters:
- RESET_RDATA, 16'h0000, reset and write-ack value of rsp_rdata.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (low byte only), 0 = 16-bit word.
- req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; byte stores use [7:0].
- rsp_valid  out  1  one-cycle pulse: load data ready or store complete.
- rsp_rdata  out  16  load result; held until the next response.
- rsp_err  out  1  valid with rsp_valid; see Optional Feature.
- mem_addr  out  16  RAM address.
- mem_data  inout  16  RAM data bus; driven only during store states, else 16'bZ.
- mem_read_en_n  out  1  RAM read enable, active-low.
- mem_write_en_n  out  1  RAM write strobe, active-low; the RAM commits on its rising edge.
- mem_ebit  out  1  RAM byte-mode select (1 = byte).

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=RESET_RDATA, mem_read_en_n=1, mem_write_en_n=1, mem_ebit=0, mem_addr=0, mem_data released (Z).
- Request capture: req_ready=1 only in IDLE. Accept when req_valid&&req_ready. On acceptance, register addr, wdata, write, byte and signed. mem_addr and mem_ebit are registered and stay stable for the whole access.
- Load sequence (T = accept cycle):
  - T+1 RD_SETUP: mem_read_en_n=0.
  - T+2 RD_CAPTURE: mem_read_en_n=0; mem_data sampled at the end of the cycle.
  - T+3 RSP: rsp_valid=1, mem_read_en_n=1.
  - Load latency is 3 cycles.
- Load result:
  - Word: mem_data[15:0].
  - Byte, unsigned: {8'h00, mem_data[7:0]}.
  - Byte, signed: {{8{mem_data[7]}}, mem_data[7:0]}. Upper bus byte is ignored.
- Store sequence:
  - T+1 WR_SETUP: mem_data driven, mem_write_en_n=1.
  - T+2 WR_STROBE: mem_write_en_n=0.
  - T+3 WR_HOLD: mem_write_en_n=1 (rising edge commits); mem_data and mem_addr still driven.
  - T+4 RSP: rsp_valid=1, rsp_rdata=RESET_RDATA, bus released.
  - Store latency is 4 cycles.
  - Byte store drives {8'h00, wdata[7:0]}.
- RSP always returns to IDLE on the next cycle. Maximum throughput: one load per 4 cycles, one store per 5 cycles.
- Bus rules:
  - mem_read_en_n=0 and mem_data driven never occur in the same cycle.
  - mem_read_en_n and mem_write_en_n are never both 0.
  - The IDLE cycle between accesses is the bus turnaround.
- req_valid while busy is ignored (not queued). The requester must hold req_valid and all request fields until accepted.
- Address 0xFFFF with a word access is passed through unchanged; the RAM's upper-byte address wraps. No special handling unless the Optional Feature is enabled.
- Reset mid-operation: all outputs return asynchronously to their reset values. No response is issued for the aborted request.
- Reset during WR_STROBE raises mem_write_en_n while the bus releases, so contents at that address are undefined. This is accepted and documented, not prevented.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined: a word request with req_addr[0]=1 is accepted but suppressed.
  - No strobe is asserted and the bus is never driven.
  - The next cycle is RSP with rsp_valid=1, rsp_err=1 and rsp_rdata unchanged.
  - Latency is 1 cycle.
- Not defined: rsp_err is tied to 0 and odd word addresses proceed as normal accesses.

Test Plan:
- Reset then idle -> req_ready=1, both strobes 1, mem_data Z, rsp_valid never pulses.
- Word store 0xBEEF @0x0010, then word load @0x0010 -> mem_write_en_n low exactly cycle T+2; load rsp_valid at T+3 with rsp_rdata=0xBEEF.
- Byte store 0x80 @0x0021, then byte load @0x0021 with req_signed=1 -> 0xFF80; with req_signed=0 -> 0x0080. Word load @0x0020 shows the 0x80 byte in [15:8] and the untouched byte 0x0020 in [7:0].
- req_valid held high for 3 back-to-back loads -> accept cycles spaced exactly 4 apart; bus-rule checker passes (no contention, no simultaneous strobes).
- rst_n asserted during RD_CAPTURE -> immediate strobe release, no rsp_valid; the next load completes normally.
- With DATA_MEM_ALIGN_CHECK_EN defined, word load @0x0011 -> rsp_valid and rsp_err at T+1, strobes never asserted. Without the macro -> normal 3-cycle load, rsp_err=0.
